// File: rtl/store_narrower.sv
// store_narrower: narrows a 32-bit store to byte/half/word lanes and buffers it for data memory.
// Latency: accepted at edge N, memValid visible right after edge N; one write per cycle in and out.
// Backpressure: reqReady = !full (no same-cycle pass-through); head held stable while memReady is low.
// Optional feature macro: STORE_NARROWER_MISALIGN_TRAP_EN (drop misaligned/illegal requests and pulse misalignErr).
module store_narrower #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [31:0]      reqAddr,
  input  logic [31:0]      reqData,
  input  logic [1:0]       reqSize,
  output logic             memValid,
  input  logic             memReady,
  output logic [31:0]      memAddr,
  output logic [31:0]      memData,
  output logic [3:0]       memByteEn,
  output logic             misalignErr,
  output logic [CNT_W-1:0] pendingCount
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Buffer storage: word address (bits [31:2]), lane-placed data, byte enables.
  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] nar_data;
  logic [3:0]  nar_be;

  assign reqReady     = (count_q != CNT_W'(DEPTH));
  assign memValid     = (count_q != '0);
  assign pendingCount = count_q;
  assign memAddr      = {addr_q[rd_ptr_q], 2'b00};
  assign memData      = data_q[rd_ptr_q];
  assign memByteEn    = be_q[rd_ptr_q];
  assign accept       = reqValid && reqReady;
  assign pop          = memValid && memReady;

  // Lane placement of the incoming register value; size 11 falls through to word.
  always_comb begin
    nar_data = reqData;
    nar_be   = 4'b1111;
    case (reqSize)
      2'b00: begin
        nar_data = {4{reqData[7:0]}};
        nar_be   = 4'b0001 << reqAddr[1:0];
      end
      2'b01: begin
        nar_data = {2{reqData[15:0]}};
        nar_be   = reqAddr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        nar_data = reqData;
        nar_be   = 4'b1111;
      end
    endcase
  end

`ifdef STORE_NARROWER_MISALIGN_TRAP_EN
  logic misalign;
  logic err_q, err_d;

  // Misaligned halfword/word and illegal size are consumed but never buffered.
  always_comb begin
    misalign = (reqSize == 2'b11) ||
               ((reqSize == 2'b01) && reqAddr[0]) ||
               ((reqSize == 2'b10) && (reqAddr[1:0] != 2'b00));
    push     = accept && !misalign;
    err_d    = accept && misalign;
  end

  // One-cycle error pulse per offending accepted request.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign misalignErr = err_q;
`else
  assign push        = accept;
  assign misalignErr = 1'b0;
`endif

  // Next-state for pointers and occupancy; push and pop together leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset discards every buffered store.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage written at the tail on push; cleared so outputs read zero out of reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else if (push) begin
      addr_q[wr_ptr_q] <= reqAddr[31:2];
      data_q[wr_ptr_q] <= nar_data;
      be_q[wr_ptr_q]   <= nar_be;
    end
  end

endmodule

// File: tb/tb_store_narrower.sv
// tb_store_narrower: scoreboard bench for store_narrower with a byte-lane reference model.
// Directed cases for alignment, full-buffer stall and reset flush, then randomized traffic.
// Builds with or without STORE_NARROWER_MISALIGN_TRAP_EN; the model follows the same macro.
module tb_store_narrower;
  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             resetN;
  logic             reqValid;
  logic             reqReady;
  logic [31:0]      reqAddr;
  logic [31:0]      reqData;
  logic [1:0]       reqSize;
  logic             memValid;
  logic             memReady;
  logic [31:0]      memAddr;
  logic [31:0]      memData;
  logic [3:0]       memByteEn;
  logic             misalignErr;
  logic [CNT_W-1:0] pendingCount;

  store_narrower #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetN(resetN),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqAddr(reqAddr), .reqData(reqData), .reqSize(reqSize),
    .memValid(memValid), .memReady(memReady),
    .memAddr(memAddr), .memData(memData), .memByteEn(memByteEn),
    .misalignErr(misalignErr), .pendingCount(pendingCount)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   exp_err  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, req, $time);
    end
  endtask

  // Reference: memory write = bytes [off, off+n) of the aligned word, lane k carries source byte k mod n.
  function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                                output bit mis, output exp_t e);
    int n;
    int off;
    int lo;
    n  = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    lo = int'(a[1:0]);
`ifdef STORE_NARROWER_MISALIGN_TRAP_EN
    mis = (s == 2'd3) || ((lo % n) != 0);
`else
    mis = 1'b0;
`endif
    off = lo - (lo % n);
    e.a = a & 32'hFFFF_FFFC;
    for (int k = 0; k < 4; k++) begin
      e.b[k]        = (k >= off) && (k < off + n);
      e.d[8*k +: 8] = d[8*(k % n) +: 8];
    end
  endfunction

  // Monitor: per-cycle occupancy/flags against the scoreboard, head content, then record accepts.
  always @(negedge clk) begin
    if (resetN) begin
      exp_t e;
      bit   mis;
      chk("pendingCount", 32'(pendingCount), 32'(q.size()));
      chk("memValid", 32'(memValid), 32'(q.size() != 0));
      chk("reqReady", 32'(reqReady), 32'(q.size() < DEPTH));
      chk("misalignErr", 32'(misalignErr), 32'(exp_err));
      exp_err = 1'b0;
      if (memValid && q.size() > 0) begin
        chk("memAddr", memAddr, q[0].a);
        chk("memData", memData, q[0].d);
        chk("memByteEn", 32'(memByteEn), 32'(q[0].b));
        if (memReady) void'(q.pop_front());
      end
      if (reqValid && reqReady) begin
        model(reqAddr, reqData, reqSize, mis, e);
        if (mis) exp_err = 1'b1;
        else     q.push_back(e);
      end
    end
  end

  // Present a request and hold it until the handshake completes (bounded).
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    bit done;
    done     = 1'b0;
    reqValid = 1'b1;
    reqAddr  = a;
    reqData  = d;
    reqSize  = s;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (reqReady) done = 1'b1;
      @(posedge clk);
      #1;
    end
    reqValid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted addr=%h", a);
    end
  endtask

  task automatic idle(input int n);
    reqValid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    resetN   = 1'b0;
    reqValid = 1'b0;
    reqAddr  = '0;
    reqData  = '0;
    reqSize  = '0;
    memReady = 1'b0;
    #3;
    chk("rst_memValid", 32'(memValid), 32'd0);
    chk("rst_pending", 32'(pendingCount), 32'd0);
    chk("rst_memAddr", memAddr, 32'd0);
    chk("rst_memData", memData, 32'd0);
    chk("rst_memByteEn", 32'(memByteEn), 32'd0);
    chk("rst_misalignErr", 32'(misalignErr), 32'd0);
    chk("rst_reqReady", 32'(reqReady), 32'd1);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;

    // Byte, halfword, word placement.
    memReady = 1'b1;
    send(32'h0000_1003, 32'hAABB_CCDD, 2'b00);
    send(32'h0000_2002, 32'h1234_5678, 2'b01);
    send(32'h0000_2004, 32'hCAFE_F00D, 2'b10);
    send(32'h0000_4001, 32'h0000_0099, 2'b00);
    send(32'h0000_4000, 32'h0000_BEEF, 2'b01);
    idle(3);

    // Fill while stalled, hold a third request, stall 5 cycles, then drain.
    memReady = 1'b0;
    send(32'h0000_5000, 32'h1111_1111, 2'b10);
    send(32'h0000_5006, 32'h2222_3333, 2'b01);
    reqValid = 1'b1;
    reqAddr  = 32'h0000_5008;
    reqData  = 32'h4444_5555;
    reqSize  = 2'b10;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    memReady = 1'b1;
    send(32'h0000_5008, 32'h4444_5555, 2'b10);
    idle(4);

    // Misaligned word, misaligned halfword, illegal size, back-to-back.
    send(32'h0000_3002, 32'hDEAD_BEEF, 2'b10);
    send(32'h0000_3001, 32'h0BAD_F00D, 2'b01);
    send(32'h0000_3000, 32'h7654_3210, 2'b11);
    idle(3);

    // Reset while two stores are pending.
    memReady = 1'b0;
    send(32'h0000_6000, 32'hAAAA_AAAA, 2'b10);
    send(32'h0000_6004, 32'hBBBB_BBBB, 2'b10);
    #2 resetN = 1'b0;
    #1;
    chk("midrst_memValid", 32'(memValid), 32'd0);
    chk("midrst_pending", 32'(pendingCount), 32'd0);
    q.delete();
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    memReady = 1'b1;
    idle(4);

    // Randomized traffic with random backpressure.
    repeat (800) begin
      reqValid = ($urandom_range(0, 9) < 7);
      reqAddr  = $urandom;
      reqData  = $urandom;
      reqSize  = 2'($urandom_range(0, 3));
      memReady = ($urandom_range(0, 9) < 6);
      @(posedge clk);
      #1;
    end

    reqValid = 1'b0;
    memReady = 1'b1;
    idle(10);
    chk("final_pending", 32'(pendingCount), 32'(q.size()));
    chk("final_drained", 32'(memValid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
